// File: rtl/mux_scan_pkg.sv
// Shared channel geometry and FSM encoding for the mux scan sequencer.
package mux_scan_pkg;
   localparam int NUM_CH = 4;
   localparam int CH_W   = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DWELL = 2'd1,
      ROUTE = 2'd2
   } state_t;
endpackage

// File: rtl/mux_scan_next.sv
// Channel picker: lowest set mask bit, and the next enabled channel above cur_ch.
module mux_scan_next
   import mux_scan_pkg::*;
(
   input  logic [NUM_CH-1:0] mask,
   input  logic [CH_W-1:0]   cur_ch,
   output logic [CH_W-1:0]   next_ch,
   output logic              has_next,
   output logic [CH_W-1:0]   first_ch
);
   // Descending walk so the lowest qualifying bit is the last one written.
   always_comb begin
      next_ch  = cur_ch;
      has_next = 1'b0;
      first_ch = '0;
      for (int i = NUM_CH-1; i >= 0; i--) begin
         if (mask[i]) first_ch = CH_W'(i);
         if (mask[i] && (i > int'(cur_ch))) begin
            has_next = 1'b1;
            next_ch  = CH_W'(i);
         end
      end
   end
endmodule

// File: rtl/mux_scan_sequencer.sv
// Scans enabled mux channels, samples each after a dwell, and routes it to the dmux.
// Build option: define MUX_SCAN_VOTE_EN to capture a majority vote over the dwell.
module mux_scan_sequencer
   import mux_scan_pkg::*;
#(
   parameter int DWELL_CYCLES = 4,
   parameter int CNT_W        = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              stop,
   input  logic              cont,
   input  logic [NUM_CH-1:0] ch_mask,
   input  logic              sample_in,
   output logic [CH_W-1:0]   mux_sel,
   output logic [CH_W-1:0]   dmux_sel,
   output logic              dmux_en,
   output logic              dmux_data,
   output logic              busy,
   output logic              frame_done
);
   state_t              state, state_nxt;
   logic [CH_W-1:0]     cur_ch, cur_nxt;
   logic [NUM_CH-1:0]   mask_lat, mask_nxt;
   logic                cont_lat, cont_nxt;
   logic [CNT_W-1:0]    cnt, cnt_nxt;
   logic                stop_pending, stop_nxt;
   logic [CH_W-1:0]     mux_sel_nxt, dmux_sel_nxt;
   logic                dmux_en_nxt, data_nxt, frame_done_nxt;
   logic                captured;

   logic [CH_W-1:0]     next_ch, first_in;
   logic                has_next;
   logic [CH_W-1:0]     first_unused, next_unused;
   logic                has_unused;

   mux_scan_next u_next (
      .mask     (mask_lat),
      .cur_ch   (cur_ch),
      .next_ch  (next_ch),
      .has_next (has_next),
      .first_ch (first_unused)
   );

   // Second picker looks at the live mask for start and continuous wrap.
   mux_scan_next u_first (
      .mask     (ch_mask),
      .cur_ch   ('0),
      .next_ch  (next_unused),
      .has_next (has_unused),
      .first_ch (first_in)
   );

`ifdef MUX_SCAN_VOTE_EN
   logic [CNT_W-1:0] ones, ones_nxt;
   logic [CNT_W:0]   ones_tot;

   assign ones_tot = {1'b0, ones} + {{CNT_W{1'b0}}, sample_in};
   assign captured = {ones_tot, 1'b0} > (CNT_W+2)'(DWELL_CYCLES);
   // Anything other than DWELL->DWELL either enters a new dwell or leaves one.
   assign ones_nxt = (state == DWELL && state_nxt == DWELL) ? ones_tot[CNT_W-1:0] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) ones <= '0;
      else     ones <= ones_nxt;
   end
`else
   assign captured = sample_in;
`endif

   always_comb begin
      state_nxt      = state;
      cur_nxt        = cur_ch;
      mask_nxt       = mask_lat;
      cont_nxt       = cont_lat;
      cnt_nxt        = cnt;
      stop_nxt       = stop_pending;
      mux_sel_nxt    = mux_sel;
      dmux_sel_nxt   = dmux_sel;
      dmux_en_nxt    = 1'b0;
      data_nxt       = dmux_data;
      frame_done_nxt = 1'b0;
      unique case (state)
         IDLE: begin
            stop_nxt = 1'b0;
            if (start && !stop && (ch_mask != '0)) begin
               mask_nxt    = ch_mask;
               cont_nxt    = cont;
               cur_nxt     = first_in;
               mux_sel_nxt = first_in;
               cnt_nxt     = '0;
               state_nxt   = DWELL;
            end
         end
         DWELL: begin
            if (stop) stop_nxt = 1'b1;
            cnt_nxt = cnt + 1'b1;
            if (cnt == CNT_W'(DWELL_CYCLES-1)) begin
               data_nxt       = captured;
               dmux_en_nxt    = 1'b1;
               dmux_sel_nxt   = cur_ch;
               frame_done_nxt = !has_next;
               state_nxt      = ROUTE;
            end
         end
         ROUTE: begin
            // A stop raised during ROUTE itself still ends the scan here.
            stop_nxt = 1'b0;
            cnt_nxt  = '0;
            if (has_next && !(stop_pending || stop)) begin
               cur_nxt     = next_ch;
               mux_sel_nxt = next_ch;
               state_nxt   = DWELL;
            end else if (!has_next && cont_lat && !(stop_pending || stop)) begin
               mask_nxt = ch_mask;
               if (ch_mask != '0) begin
                  cur_nxt     = first_in;
                  mux_sel_nxt = first_in;
                  state_nxt   = DWELL;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         cur_ch       <= '0;
         mask_lat     <= '0;
         cont_lat     <= 1'b0;
         cnt          <= '0;
         stop_pending <= 1'b0;
         mux_sel      <= '0;
         dmux_sel     <= '0;
         dmux_en      <= 1'b0;
         dmux_data    <= 1'b0;
         busy         <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         state        <= state_nxt;
         cur_ch       <= cur_nxt;
         mask_lat     <= mask_nxt;
         cont_lat     <= cont_nxt;
         cnt          <= cnt_nxt;
         stop_pending <= stop_nxt;
         mux_sel      <= mux_sel_nxt;
         dmux_sel     <= dmux_sel_nxt;
         dmux_en      <= dmux_en_nxt;
         dmux_data    <= data_nxt;
         busy         <= (state_nxt != IDLE);
         frame_done   <= frame_done_nxt;
      end
   end
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Scoreboard bench for mux_scan_sequencer; vote patterns follow MUX_SCAN_VOTE_EN.
module tb_mux_scan_sequencer;
   localparam int DW = 4;

   logic       clk = 1'b0;
   logic       rst, start, stop, cont, sample_in;
   logic [3:0] ch_mask;
   logic [1:0] mux_sel, dmux_sel;
   logic       dmux_en, dmux_data, busy, frame_done;

   mux_scan_sequencer #(.DWELL_CYCLES(DW), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .stop       (stop),
      .cont       (cont),
      .ch_mask    (ch_mask),
      .sample_in  (sample_in),
      .mux_sel    (mux_sel),
      .dmux_sel   (dmux_sel),
      .dmux_en    (dmux_en),
      .dmux_data  (dmux_data),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] cyc;
      logic [1:0] sel;
      logic       data;
      logic       fd;
   } rt_t;

   rt_t  exp_q[$];
   rt_t  obs_q[$];
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   stray = 0;
   logic [1:0] msel_h [0:63];
   logic       busy_h [0:63];

   // Advance one cycle and record what the DUT shows #1 after the edge.
   task automatic tick();
      rt_t r;
      @(posedge clk);
      #1;
      cyc++;
      if (cyc < 64) begin
         msel_h[cyc] = mux_sel;
         busy_h[cyc] = busy;
      end
      if (dmux_en) begin
         r.cyc = 8'(cyc); r.sel = dmux_sel; r.data = dmux_data; r.fd = frame_done;
         obs_q.push_back(r);
      end else if (frame_done) begin
         stray++;
      end
   endtask

   task automatic run_to(input int c);
      while (cyc < c) tick();
   endtask

   task automatic begin_scan(input logic [3:0] m, input logic c);
      start = 1'b1; ch_mask = m; cont = c; cyc = 0;
      tick();
      start = 1'b0;
   endtask

   task automatic push_exp(input int c, input logic [1:0] s, input logic d, input logic fd);
      rt_t r;
      r.cyc = 8'(c); r.sel = s; r.data = d; r.fd = fd;
      exp_q.push_back(r);
   endtask

   task automatic test_reset();
      rst = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0; ch_mask = '0; sample_in = 1'b1;
      #1 rst = 1'b1;
      #2;
      checks++;
      if ({mux_sel, dmux_sel, dmux_en, dmux_data, busy, frame_done} !== 8'h00) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=00000000",
                  {mux_sel, dmux_sel, dmux_en, dmux_data, busy, frame_done});
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_full_frame();
      rt_t e, o;
      stray = 0;
      begin_scan(4'b1111, 1'b0);
      push_exp(5, 2'd0, 1'b1, 1'b0);
      push_exp(10, 2'd1, 1'b1, 1'b0);
      push_exp(15, 2'd2, 1'b1, 1'b0);
      push_exp(20, 2'd3, 1'b1, 1'b1);
      run_to(23);
      checks++;
      if (busy_h[1] !== 1'b1) begin failures++; $display("FAIL full_busy_c1 got=%b exp=1", busy_h[1]); end
      checks++;
      if (busy_h[21] !== 1'b0) begin failures++; $display("FAIL full_busy_c21 got=%b exp=0", busy_h[21]); end
      checks++;
      if (stray != 0) begin failures++; $display("FAIL full_stray_fd got=%0d exp=0", stray); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin failures++; $display("FAIL full_route missing exp=%h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL full_route got=%h exp=%h", o, e); end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL full_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_sparse();
      rt_t e, o;
      int bad;
      begin_scan(4'b1010, 1'b0);
      push_exp(5, 2'd1, 1'b1, 1'b0);
      push_exp(10, 2'd3, 1'b1, 1'b1);
      run_to(13);
      bad = 0;
      for (int c = 1; c <= 10; c++) if (msel_h[c] !== ((c <= 5) ? 2'd1 : 2'd3)) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL sparse_mux_sel bad_cycles=%0d exp=0", bad); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin failures++; $display("FAIL sparse_route missing exp=%h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL sparse_route got=%h exp=%h", o, e); end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL sparse_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_ignored_start();
      int bad;
      begin_scan(4'b0000, 1'b0);
      run_to(4);
      bad = 0;
      for (int c = 1; c <= 4; c++) if (busy_h[c] !== 1'b0) bad++;
      stop = 1'b1;
      begin_scan(4'b1111, 1'b0);
      stop = 1'b0;
      run_to(8);
      for (int c = 1; c <= 8; c++) if (busy_h[c] !== 1'b0) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL ignored_busy bad_cycles=%0d exp=0", bad); end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL ignored_route got=%0d exp=0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_stop();
      rt_t e, o;
      stray = 0;
      begin_scan(4'b1111, 1'b1);
      push_exp(5, 2'd0, 1'b1, 1'b0);
      push_exp(10, 2'd1, 1'b1, 1'b0);
      while (cyc < 16) begin
         stop = (cyc == 7);
         tick();
      end
      stop = 1'b0;
      checks++;
      if (busy_h[10] !== 1'b1 || busy_h[11] !== 1'b0) begin
         failures++; $display("FAIL stop_busy got=%b%b exp=10", busy_h[10], busy_h[11]);
      end
      checks++;
      if (stray != 0) begin failures++; $display("FAIL stop_stray_fd got=%0d exp=0", stray); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin failures++; $display("FAIL stop_route missing exp=%h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL stop_route got=%h exp=%h", o, e); end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL stop_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_continuous();
      rt_t e, o;
      begin_scan(4'b1111, 1'b1);
      push_exp(5, 2'd0, 1'b1, 1'b0);
      push_exp(10, 2'd1, 1'b1, 1'b0);
      push_exp(15, 2'd2, 1'b1, 1'b0);
      push_exp(20, 2'd3, 1'b1, 1'b1);
      push_exp(25, 2'd0, 1'b1, 1'b0);
      while (cyc < 28) begin
         stop = (cyc == 22);
         tick();
      end
      stop = 1'b0;
      checks++;
      if (msel_h[21] !== 2'd0 || busy_h[21] !== 1'b1) begin
         failures++; $display("FAIL cont_wrap got=sel%0d busy%b exp=sel0 busy1", msel_h[21], busy_h[21]);
      end
      checks++;
      if (busy_h[26] !== 1'b0) begin failures++; $display("FAIL cont_stop_busy got=%b exp=0", busy_h[26]); end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin failures++; $display("FAIL cont_route missing exp=%h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL cont_route got=%h exp=%h", o, e); end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL cont_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_reset_midframe();
      rt_t e, o;
      begin_scan(4'b1111, 1'b0);
      run_to(3);
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({mux_sel, dmux_sel, dmux_en, dmux_data, busy, frame_done} !== 8'h00) begin
         failures++;
         $display("FAIL midreset_outputs got=%b exp=00000000",
                  {mux_sel, dmux_sel, dmux_en, dmux_data, busy, frame_done});
      end
      @(posedge clk);
      #1 rst = 1'b0;
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL midreset_route got=%0d exp=0", obs_q.size()); obs_q.delete(); end
      begin_scan(4'b0100, 1'b0);
      push_exp(DW+1, 2'd2, 1'b1, 1'b1);
      run_to(8);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin failures++; $display("FAIL midreset_route missing exp=%h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL midreset_route got=%h exp=%h", o, e); end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL midreset_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
   endtask

   task automatic test_vote();
      rt_t e, o;
      logic [3:0] pat [0:1];
      logic       want [0:1];
`ifdef MUX_SCAN_VOTE_EN
      pat[0] = 4'b1100; want[0] = 1'b0;
      pat[1] = 4'b1110; want[1] = 1'b1;
`else
      pat[0] = 4'b0001; want[0] = 1'b1;
      pat[1] = 4'b1110; want[1] = 1'b0;
`endif
      for (int r = 0; r < 2; r++) begin
         begin_scan(4'b0001, 1'b0);
         push_exp(5, 2'd0, want[r], 1'b1);
         for (int k = 0; k < 4; k++) begin
            sample_in = pat[r][3-k];
            tick();
         end
         sample_in = 1'b1;
         run_to(7);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front(); checks++;
         if (obs_q.size() == 0) begin failures++; $display("FAIL vote_route missing exp=%h", e); end
         else begin
            o = obs_q.pop_front();
            if (o !== e) begin failures++; $display("FAIL vote_route got=%h exp=%h", o, e); end
         end
      end
      checks++;
      if (obs_q.size() != 0) begin failures++; $display("FAIL vote_extra got=%0d exp=0", obs_q.size()); obs_q.delete(); end
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_sparse();
      test_ignored_start();
      test_stop();
      test_continuous();
      test_reset_midframe();
      test_vote();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time_limit_reached");
      $fatal(1, "timeout");
   end
endmodule
